// File: rtl/dma_isr_req_splitter.sv
// dma_isr_req_splitter
//   Consumer end of the DMA ISR request path. It accepts host<->card transfer requests and
//   splits each one into descriptors that never cross a MAX_CHUNK-aligned host-address
//   boundary. The descriptors go to the DMA engine. In-order descriptor completions are then
//   folded back into one done pulse per request, plus an irq pulse if the request asked for one.
//
// Ports
//   aclk_i, aresetn_i        clock, asynchronous active-low reset
//   s_req_*                  request channel (valid/ready, paddr, vaddr, len, isr)
//   m_dsc_*                  descriptor channel (valid/ready, paddr, vaddr, len), registered
//   dsc_done_i               one pulse per completed descriptor, in issue order
//   m_done_o, m_irq_o        1-cycle pulses when the oldest outstanding request completes
//   outstanding_o            tracker occupancy
//   err_unexp_o              sticky: dsc_done_i seen with the tracker empty
module dma_isr_req_splitter #(
  parameter int unsigned ADDR_BITS     = 64,
  parameter int unsigned LEN_BITS      = 28,
  parameter int unsigned MAX_CHUNK     = 4096,
  parameter int unsigned N_OUTSTANDING = 8
) (
  input  logic                             aclk_i,
  input  logic                             aresetn_i,
  // request channel
  input  logic                             s_req_valid_i,
  output logic                             s_req_ready_o,
  input  logic [ADDR_BITS-1:0]             s_req_paddr_i,
  input  logic [ADDR_BITS-1:0]             s_req_vaddr_i,
  input  logic [LEN_BITS-1:0]              s_req_len_i,
  input  logic                             s_req_isr_i,
  // descriptor channel
  output logic                             m_dsc_valid_o,
  input  logic                             m_dsc_ready_i,
  output logic [ADDR_BITS-1:0]             m_dsc_paddr_o,
  output logic [ADDR_BITS-1:0]             m_dsc_vaddr_o,
  output logic [LEN_BITS-1:0]              m_dsc_len_o,
  // completion side
  input  logic                             dsc_done_i,
  output logic                             m_done_o,
  output logic                             m_irq_o,
  output logic [$clog2(N_OUTSTANDING):0]   outstanding_o,
  output logic                             err_unexp_o
);

  localparam int unsigned ChunkLog = $clog2(MAX_CHUNK);
  localparam int unsigned CntW     = LEN_BITS - ChunkLog + 2;
  localparam int unsigned PtrW     = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;
  localparam int unsigned OccW     = $clog2(N_OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StSplit,
    StWait    // stream finished, tracker full: hold the push until a slot frees
  } state_e;

  // Bytes left before the next MAX_CHUNK boundary, clipped to the remaining length.
  function automatic logic [LEN_BITS-1:0] chunk_len(input logic [ChunkLog-1:0] offset,
                                                     input logic [LEN_BITS-1:0] rem);
    logic [LEN_BITS-1:0] room;
    room = LEN_BITS'(MAX_CHUNK) - LEN_BITS'(offset);
    return (rem < room) ? rem : room;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Splitter state
  // ---------------------------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  init_q;
  logic [ADDR_BITS-1:0]  paddr_q, paddr_d;
  logic [ADDR_BITS-1:0]  vaddr_q, vaddr_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic                  isr_q, isr_d;
  logic [CntW-1:0]       chunk_cnt_q, chunk_cnt_d;
  logic                  dsc_valid_q, dsc_valid_d;
  logic [LEN_BITS-1:0]   dsc_len_q, dsc_len_d;

  // tracker interface
  logic                  push;
  logic                  push_isr;
  logic [CntW-1:0]       push_cnt;
  logic                  pop;
  logic                  trk_empty;
  logic                  trk_full;
  logic                  req_ready;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    vaddr_d     = vaddr_q;
    rem_d       = rem_q;
    isr_d       = isr_q;
    chunk_cnt_d = chunk_cnt_q;
    dsc_valid_d = dsc_valid_q;
    dsc_len_d   = dsc_len_q;
    push        = 1'b0;
    push_isr    = isr_q;
    push_cnt    = chunk_cnt_q;
    req_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = init_q && !trk_full;
        if (s_req_valid_i && req_ready) begin
          paddr_d     = s_req_paddr_i;
          vaddr_d     = s_req_vaddr_i;
          rem_d       = s_req_len_i;
          isr_d       = s_req_isr_i;
          chunk_cnt_d = '0;
          if (s_req_len_i == '0) begin
            // Zero-length request: tracked, but produces no descriptor.
            push     = 1'b1;
            push_isr = s_req_isr_i;
            push_cnt = '0;
          end else begin
            // First descriptor is ready the cycle after accept.
            dsc_len_d   = chunk_len(s_req_paddr_i[ChunkLog-1:0], s_req_len_i);
            dsc_valid_d = 1'b1;
            state_d     = StSplit;
          end
        end
      end

      StSplit: begin
        if (dsc_valid_q && m_dsc_ready_i) begin
          paddr_d     = paddr_q + ADDR_BITS'(dsc_len_q);
          vaddr_d     = vaddr_q + ADDR_BITS'(dsc_len_q);
          rem_d       = rem_q - dsc_len_q;
          chunk_cnt_d = chunk_cnt_q + CntW'(1);
          // Precompute the following descriptor so handshakes can run every cycle.
          dsc_len_d   = chunk_len(paddr_d[ChunkLog-1:0], rem_d);
          if (rem_d == '0) begin
            dsc_valid_d = 1'b0;
            if (!trk_full) begin
              push     = 1'b1;
              push_cnt = chunk_cnt_d;
              state_d  = StIdle;
            end else begin
              state_d  = StWait;
            end
          end
        end
      end

      StWait: begin
        if (!trk_full) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      paddr_q     <= '0;
      vaddr_q     <= '0;
      rem_q       <= '0;
      isr_q       <= 1'b0;
      chunk_cnt_q <= '0;
      dsc_valid_q <= 1'b0;
      dsc_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      paddr_q     <= paddr_d;
      vaddr_q     <= vaddr_d;
      rem_q       <= rem_d;
      isr_q       <= isr_d;
      chunk_cnt_q <= chunk_cnt_d;
      dsc_valid_q <= dsc_valid_d;
      dsc_len_q   <= dsc_len_d;
    end
  end

  assign s_req_ready_o = req_ready;
  assign m_dsc_valid_o = dsc_valid_q;
  assign m_dsc_paddr_o = paddr_q;
  assign m_dsc_vaddr_o = vaddr_q;
  assign m_dsc_len_o   = dsc_len_q;

  // ---------------------------------------------------------------------------------------------
  // Completion tracker: FIFO of {isr, descriptor count}, one entry per accepted request
  // ---------------------------------------------------------------------------------------------
  logic [CntW:0]     mem_q [N_OUTSTANDING];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [OccW-1:0]   count_q, count_d;
  logic [CntW-1:0]   done_seen_q, done_seen_d;
  logic [CntW:0]     head_ent;
  logic              head_isr;
  logic [CntW-1:0]   head_cnt;
  logic              done_inc;
  logic [CntW-1:0]   done_total;
  logic              done_q;
  logic              irq_q;
  logic              err_q;

  assign trk_empty = (count_q == '0);
  assign trk_full  = (count_q == OccW'(N_OUTSTANDING));
  assign head_ent  = mem_q[rd_ptr_q];
  assign head_isr  = head_ent[CntW];
  assign head_cnt  = head_ent[CntW-1:0];

  // done_seen_q counts completions credited to the head entry. A completion arriving while a
  // zero-count entry sits at the head belongs to a later request, so any surplus is carried
  // over to the next head instead of being lost.
  always_comb begin
    done_inc    = dsc_done_i && !trk_empty;
    done_total  = done_seen_q + CntW'(done_inc);
    pop         = !trk_empty && (done_total >= head_cnt);
    done_seen_d = done_seen_q;
    if (pop) begin
      done_seen_d = done_total - head_cnt;
    end else if (!trk_empty) begin
      done_seen_d = done_total;
    end
    count_d = count_q + OccW'(push) - OccW'(pop);
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < int'(N_OUTSTANDING); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_seen_q <= '0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_isr, push_cnt};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q     <= count_d;
      done_seen_q <= done_seen_d;
      done_q      <= pop;
      irq_q       <= pop && head_isr;
      if (dsc_done_i && trk_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign m_done_o      = done_q;
  assign m_irq_o       = irq_q;
  assign outstanding_o = count_q;
  assign err_unexp_o   = err_q;

endmodule
